// File: rtl/hba_pkg.sv
// Shared constants, FSM state type and a width helper for the HBA bus arbiter.
package hba_pkg;

  localparam int unsigned HBA_DBUS_WIDTH = 8;
  localparam int unsigned HBA_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_t;

  // Bits needed to index n items; never less than 1.
  function automatic int unsigned hba_clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hba_rr_picker.sv
// Rotating-priority encoder: the first requester after last_owner wins, wrapping to 0.
module hba_rr_picker
  import hba_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned OWNER_W     = hba_clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [OWNER_W-1:0]     last_owner_i,
  output logic                   any_o,
  output logic [OWNER_W-1:0]     winner_o
);

  // Scan masters above last_owner first, then wrap to 0 .. last_owner.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    for (int j = 0; j < int'(NUM_MASTERS); j++) begin
      if (!any_o && req_i[j] && (j > int'(last_owner_i))) begin
        any_o    = 1'b1;
        winner_o = OWNER_W'(j);
      end
    end
    for (int j = 0; j < int'(NUM_MASTERS); j++) begin
      if (!any_o && req_i[j] && (j <= int'(last_owner_i))) begin
        any_o    = 1'b1;
        winner_o = OWNER_W'(j);
      end
    end
  end

endmodule

// File: rtl/hba_arbiter.sv
// Round-robin owner arbiter for the HBA bus: IDLE -> GRANT -> RELEASE (one turnaround cycle).
// Optional feature macro HBA_ARB_TIMEOUT_EN: forced release after TIMEOUT_CYCLES without xferack.
module hba_arbiter
  import hba_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DBUS_WIDTH     = HBA_DBUS_WIDTH,
  parameter int unsigned ADDR_WIDTH     = HBA_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             hba_clk,
  input  logic                             hba_reset,
  input  logic [NUM_MASTERS-1:0]           m_request,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_abus,
  input  logic [NUM_MASTERS-1:0]           m_rnw,
  input  logic [NUM_MASTERS-1:0]           m_select,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] m_dbus,
  input  logic                             hba_xferack,
  output logic [NUM_MASTERS-1:0]           hba_mgrant,
  output logic [ADDR_WIDTH-1:0]            hba_abus,
  output logic                             hba_rnw,
  output logic                             hba_select,
  output logic [DBUS_WIDTH-1:0]            hba_mdbus,
  output logic [2:0]                       arb_owner,
  output logic                             arb_timeout
);

  localparam int unsigned OwnerW = hba_clog2(NUM_MASTERS);

  arb_state_t              state_q, state_d;
  logic [OwnerW-1:0]       owner_q, owner_d;
  logic [OwnerW-1:0]       last_owner_q, last_owner_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic                    pick_any;
  logic [OwnerW-1:0]       pick_idx;
  logic                    owner_done;
  logic                    timeout_hit;

  hba_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .OWNER_W     (OwnerW)
  ) u_picker (
    .req_i        (m_request),
    .last_owner_i (last_owner_q),
    .any_o        (pick_any),
    .winner_o     (pick_idx)
  );

  // Owner may leave only once it has neither a request nor a transfer in flight.
  assign owner_done = ~m_request[owner_q] & ~m_select[owner_q];

`ifdef HBA_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt_q, hold_cnt_d;

  assign timeout_hit = (state_q == GRANT) && (hold_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Hold counter: zero while idle so it starts at 0 on grant; xferack restarts it.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE) begin
      hold_cnt_d = '0;
    end else if (state_q == GRANT) begin
      hold_cnt_d = hba_xferack ? '0 : hold_cnt_q + 16'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge hba_clk) begin
    if (hba_reset) hold_cnt_q <= '0;
    else           hold_cnt_q <= hold_cnt_d;
  end
`else
  logic unused_xferack;
  assign unused_xferack = hba_xferack ^ (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  // State, owner and registered grant.
  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OwnerW'(NUM_MASTERS - 1);
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
    end
  end

  // Next state; grant follows the next state so it is visible in the first GRANT cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          state_d      = GRANT;
        end
      end
      GRANT:   if (owner_done || timeout_hit) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    grant_d = '0;
    if (state_d == GRANT) grant_d[owner_d] = 1'b1;
  end

  // Bus mux gated by the one-hot grant; non-owners contribute nothing.
  always_comb begin
    hba_abus  = '0;
    hba_rnw   = 1'b0;
    hba_select = 1'b0;
    hba_mdbus = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (grant_q[i]) begin
        hba_abus   = m_abus[i*ADDR_WIDTH +: ADDR_WIDTH];
        hba_rnw    = m_rnw[i];
        hba_select = m_select[i];
        hba_mdbus  = m_dbus[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
    hba_mgrant  = grant_q;
    arb_owner   = 3'(owner_q);
    arb_timeout = timeout_hit;
  end

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed bench for hba_arbiter (2 masters) with an expectation queue per clock step.
module tb_hba_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic               hba_clk = 1'b0;
  logic               hba_reset;
  logic [NM-1:0]      m_request;
  logic [NM*AW-1:0]   m_abus;
  logic [NM-1:0]      m_rnw;
  logic [NM-1:0]      m_select;
  logic [NM*DW-1:0]   m_dbus;
  logic               hba_xferack;
  logic [NM-1:0]      hba_mgrant;
  logic [AW-1:0]      hba_abus;
  logic               hba_rnw;
  logic               hba_select;
  logic [DW-1:0]      hba_mdbus;
  logic [2:0]         arb_owner;
  logic               arb_timeout;

  typedef struct packed {
    logic [1:0]  grant;
    logic [11:0] abus;
    logic        rnw;
    logic        sel;
    logic [7:0]  dbus;
    logic [2:0]  owner;
    logic        tmo;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  hba_arbiter #(
    .NUM_MASTERS    (NM),
    .DBUS_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .hba_clk     (hba_clk),
    .hba_reset   (hba_reset),
    .m_request   (m_request),
    .m_abus      (m_abus),
    .m_rnw       (m_rnw),
    .m_select    (m_select),
    .m_dbus      (m_dbus),
    .hba_xferack (hba_xferack),
    .hba_mgrant  (hba_mgrant),
    .hba_abus    (hba_abus),
    .hba_rnw     (hba_rnw),
    .hba_select  (hba_select),
    .hba_mdbus   (hba_mdbus),
    .arb_owner   (arb_owner),
    .arb_timeout (arb_timeout)
  );

  always #5 hba_clk = ~hba_clk;

  // Queue the expected post-edge outputs for the current inputs, clock once, then check.
  task automatic step(input string tag, input logic [1:0] eg, input logic [2:0] eo,
                      input logic et);
    obs_t e;
    obs_t o;
    obs_t x;
    string t;
    e       = '0;
    e.grant = eg;
    if (eg == 2'b01) begin
      e.abus = m_abus[11:0];  e.rnw = m_rnw[0]; e.sel = m_select[0]; e.dbus = m_dbus[7:0];
    end else if (eg == 2'b10) begin
      e.abus = m_abus[23:12]; e.rnw = m_rnw[1]; e.sel = m_select[1]; e.dbus = m_dbus[15:8];
    end
    e.owner = eo;
    e.tmo   = et;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge hba_clk);
    #1;
    o = '{grant: hba_mgrant, abus: hba_abus, rnw: hba_rnw, sel: hba_select,
          dbus: hba_mdbus, owner: arb_owner, tmo: arb_timeout};
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (o === x) else begin
      miscompares++;
      $error("FAIL %s: observed grant=%b abus=%h rnw=%b sel=%b dbus=%h owner=%0d tmo=%b, expected grant=%b abus=%h rnw=%b sel=%b dbus=%h owner=%0d tmo=%b",
             t, o.grant, o.abus, o.rnw, o.sel, o.dbus, o.owner, o.tmo,
             x.grant, x.abus, x.rnw, x.sel, x.dbus, x.owner, x.tmo);
    end
  endtask

  initial begin
    hba_reset   = 1'b1;
    m_request   = 2'b00;
    m_abus      = {12'h2AB, 12'h105};
    m_rnw       = 2'b11;
    m_select    = 2'b11;
    m_dbus      = {8'h5A, 8'hA5};
    hba_xferack = 1'b0;

    // Reset: everything zero even with live master inputs.
    step("rst0", 2'b00, 3'd0, 1'b0);
    step("rst1", 2'b00, 3'd0, 1'b0);

    // 1: single requester.
    hba_reset = 1'b0;
    m_select  = 2'b00;
    step("t1_idle", 2'b00, 3'd0, 1'b0);
    m_request = 2'b01;
    m_select  = 2'b01;
    step("t1_grant", 2'b01, 3'd0, 1'b0);
    step("t1_hold", 2'b01, 3'd0, 1'b0);
    m_request = 2'b00;
    m_select  = 2'b00;
    step("t1_release", 2'b00, 3'd0, 1'b0);
    step("t1_idle2", 2'b00, 3'd0, 1'b0);

    // 2: contention from reset; master 0 first, then 1, then back to 0.
    hba_reset = 1'b1;
    step("t2_rst", 2'b00, 3'd0, 1'b0);
    hba_reset = 1'b0;
    m_request = 2'b11;
    step("t2_grant0", 2'b01, 3'd0, 1'b0);
    step("t2_hold0", 2'b01, 3'd0, 1'b0);
    m_request = 2'b10;
    step("t2_release0", 2'b00, 3'd0, 1'b0);
    step("t2_idle", 2'b00, 3'd0, 1'b0);
    m_select  = 2'b10;
    step("t2_grant1", 2'b10, 3'd1, 1'b0);
    m_request = 2'b11;
    step("t2_hold1", 2'b10, 3'd1, 1'b0);
    m_request = 2'b01;
    m_select  = 2'b00;
    step("t2_release1", 2'b00, 3'd1, 1'b0);
    step("t2_idle2", 2'b00, 3'd1, 1'b0);
    step("t2_grant0b", 2'b01, 3'd0, 1'b0);

    // 4: non-owner activity never reaches the bus.
    m_abus   = {12'hFFF, 12'h105};
    m_rnw    = 2'b10;
    m_dbus   = {8'hEE, 8'h3C};
    m_select = 2'b11;
    step("t4_sel_both", 2'b01, 3'd0, 1'b0);
    m_select = 2'b10;
    step("t4_sel_other", 2'b01, 3'd0, 1'b0);

    // 3: request dropped with select still high keeps the grant.
    m_request = 2'b00;
    m_select  = 2'b01;
    step("t3_sel1", 2'b01, 3'd0, 1'b0);
    step("t3_sel2", 2'b01, 3'd0, 1'b0);
    step("t3_sel3", 2'b01, 3'd0, 1'b0);
    m_select = 2'b00;
    step("t3_release", 2'b00, 3'd0, 1'b0);
    step("t3_idle", 2'b00, 3'd0, 1'b0);

    // 5: stuck master 0 with master 1 pending.
    hba_reset = 1'b1;
    step("t5_rst", 2'b00, 3'd0, 1'b0);
    hba_reset = 1'b0;
    m_request = 2'b11;
    step("t5_c1", 2'b01, 3'd0, 1'b0);
`ifdef HBA_ARB_TIMEOUT_EN
    for (int k = 2; k <= 16; k++) begin
      step($sformatf("t5_c%0d", k), 2'b01, 3'd0, k == 16);
    end
    step("t5_release", 2'b00, 3'd0, 1'b0);
    step("t5_idle", 2'b00, 3'd0, 1'b0);
    step("t5_grant1", 2'b10, 3'd1, 1'b0);
`else
    for (int k = 2; k <= 20; k++) begin
      step($sformatf("t5_hold%0d", k), 2'b01, 3'd0, 1'b0);
    end
`endif

    // 6: reset mid-grant drops it at once; master 0 wins the next tie.
    hba_reset = 1'b1;
    step("t6_rst", 2'b00, 3'd0, 1'b0);
    hba_reset = 1'b0;
    step("t6_grant0", 2'b01, 3'd0, 1'b0);
    step("t6_hold0", 2'b01, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
